// File: rtl/accelerator_lstm_pkg.sv
// Shared definitions for the LSTM accelerator blocks: FSM encoding and
// single-bit strobe / capture-flag constants.
package accelerator_lstm_pkg;

   typedef enum logic [2:0] {
      STARTER  = 3'd0,
      INPUT    = 3'd1,
      MULTIPLY = 3'd2,
      ADDER    = 3'd3,
      OUTPUT   = 3'd4
   } state_t;

   localparam logic ZERO_DATA = 1'b0;
   localparam logic ONE_DATA  = 1'b1;
   localparam logic FULL      = 1'b1;
   localparam logic EMPTY     = 1'b0;

endpackage

// File: rtl/accelerator_scalar_fixed_multiplier.sv
// Combinational signed fixed-point multiply (DATA_SIZE/2 fraction bits, floor rounding).
// Clamps on overflow when ACCELERATOR_STATE_VECTOR_SATURATION_EN is defined, wraps otherwise.
module accelerator_scalar_fixed_multiplier
   import accelerator_lstm_pkg::*;
#(
   parameter int DATA_SIZE = 64
) (
   input  logic [DATA_SIZE-1:0] DATA_A_IN,
   input  logic [DATA_SIZE-1:0] DATA_B_IN,
   output logic [DATA_SIZE-1:0] DATA_OUT
);

   logic signed [2*DATA_SIZE-1:0] product_s;
   logic signed [2*DATA_SIZE-1:0] scaled_s;

`ifdef ACCELERATOR_STATE_VECTOR_SATURATION_EN
   localparam logic signed [2*DATA_SIZE-1:0] WIDE_MAX = {{(DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [2*DATA_SIZE-1:0] WIDE_MIN = {{(DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
`endif

   // Full-width product, arithmetic shift floors toward minus infinity
   always_comb begin
      product_s = $signed(DATA_A_IN) * $signed(DATA_B_IN);
      scaled_s  = product_s >>> (DATA_SIZE/2);
`ifdef ACCELERATOR_STATE_VECTOR_SATURATION_EN
      if (scaled_s > WIDE_MAX) begin
         DATA_OUT = {1'b0, {(DATA_SIZE-1){1'b1}}};
      end else if (scaled_s < WIDE_MIN) begin
         DATA_OUT = {1'b1, {(DATA_SIZE-1){1'b0}}};
      end else begin
         DATA_OUT = DATA_SIZE'(scaled_s);
      end
`else
      DATA_OUT = DATA_SIZE'(scaled_s);
`endif
   end

endmodule

// File: rtl/accelerator_state_vector.sv
// LSTM cell-state update s(t;l) = f*s(t-1) + i*a, one element per pass through the FSM.
// Define ACCELERATOR_STATE_VECTOR_SATURATION_EN to clamp overflow instead of wrapping.
module accelerator_state_vector
   import accelerator_lstm_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic [DATA_SIZE-1:0] SIZE_L_IN,
   input  logic [DATA_SIZE-1:0] F_IN,
   input  logic [DATA_SIZE-1:0] I_IN,
   input  logic [DATA_SIZE-1:0] A_IN,
   input  logic [DATA_SIZE-1:0] S_PREV_IN,
   input  logic                 F_IN_ENABLE,
   input  logic                 I_IN_ENABLE,
   input  logic                 A_IN_ENABLE,
   input  logic                 S_PREV_IN_ENABLE,
   output logic                 F_OUT_ENABLE,
   output logic                 I_OUT_ENABLE,
   output logic                 A_OUT_ENABLE,
   output logic                 S_PREV_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] S_OUT,
   output logic                 S_OUT_ENABLE
);

   localparam int CMP_SIZE = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;
   localparam logic [DATA_SIZE-1:0] ZERO_WORD = {DATA_SIZE{1'b0}};

   state_t                  state_r;
   logic [CONTROL_SIZE-1:0] index_r;
   logic [DATA_SIZE-1:0]    size_l_r;
   logic [DATA_SIZE-1:0]    f_r, i_r, a_r, s_prev_r;
   logic                    f_full_r, i_full_r, a_full_r, s_full_r;
   logic [DATA_SIZE-1:0]    fs_product_r, ia_product_r;
   logic [DATA_SIZE-1:0]    s_out_r;
   logic                    s_out_enable_r, ready_r, request_r;

   logic [DATA_SIZE-1:0]    fs_product_s, ia_product_s;
   logic signed [DATA_SIZE:0] sum_s;
   logic                    f_full_s, i_full_s, a_full_s, s_full_s;
   logic                    last_element_s;

   function automatic logic [DATA_SIZE-1:0] reduce_sum(input logic signed [DATA_SIZE:0] sum);
`ifdef ACCELERATOR_STATE_VECTOR_SATURATION_EN
      if (sum[DATA_SIZE] != sum[DATA_SIZE-1]) begin
         reduce_sum = sum[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
      end else begin
         reduce_sum = DATA_SIZE'(sum);
      end
`else
      reduce_sum = DATA_SIZE'(sum);
`endif
   endfunction

   accelerator_scalar_fixed_multiplier #(.DATA_SIZE(DATA_SIZE)) u_fs_multiplier (
      .DATA_A_IN (f_r),
      .DATA_B_IN (s_prev_r),
      .DATA_OUT  (fs_product_s)
   );

   accelerator_scalar_fixed_multiplier #(.DATA_SIZE(DATA_SIZE)) u_ia_multiplier (
      .DATA_A_IN (i_r),
      .DATA_B_IN (a_r),
      .DATA_OUT  (ia_product_s)
   );

   assign f_full_s = f_full_r | F_IN_ENABLE;
   assign i_full_s = i_full_r | I_IN_ENABLE;
   assign a_full_s = a_full_r | A_IN_ENABLE;
   assign s_full_s = s_full_r | S_PREV_IN_ENABLE;
   assign sum_s    = {fs_product_r[DATA_SIZE-1], fs_product_r} + {ia_product_r[DATA_SIZE-1], ia_product_r};
   assign last_element_s = (CMP_SIZE'(index_r) + CMP_SIZE'(1'b1)) >= CMP_SIZE'(size_l_r);

   // Element sequencer: operand capture, product/sum pipeline and handshake strobes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r        <= STARTER;
         index_r        <= {CONTROL_SIZE{1'b0}};
         size_l_r       <= ZERO_WORD;
         f_r            <= ZERO_WORD;
         i_r            <= ZERO_WORD;
         a_r            <= ZERO_WORD;
         s_prev_r       <= ZERO_WORD;
         f_full_r       <= EMPTY;
         i_full_r       <= EMPTY;
         a_full_r       <= EMPTY;
         s_full_r       <= EMPTY;
         fs_product_r   <= ZERO_WORD;
         ia_product_r   <= ZERO_WORD;
         s_out_r        <= ZERO_WORD;
         s_out_enable_r <= ZERO_DATA;
         ready_r        <= ZERO_DATA;
         request_r      <= ZERO_DATA;
      end else begin
         s_out_enable_r <= ZERO_DATA;
         ready_r        <= ZERO_DATA;
         request_r      <= ZERO_DATA;
         case (state_r)
            STARTER: begin
               if (START) begin
                  size_l_r <= SIZE_L_IN;
                  index_r  <= {CONTROL_SIZE{1'b0}};
                  if (SIZE_L_IN == ZERO_WORD) begin
                     ready_r <= ONE_DATA;
                  end else begin
                     request_r <= ONE_DATA;
                     state_r   <= INPUT;
                  end
               end
            end
            INPUT: begin
               if (F_IN_ENABLE)      f_r      <= F_IN;
               if (I_IN_ENABLE)      i_r      <= I_IN;
               if (A_IN_ENABLE)      a_r      <= A_IN;
               if (S_PREV_IN_ENABLE) s_prev_r <= S_PREV_IN;
               if (f_full_s && i_full_s && a_full_s && s_full_s) begin
                  f_full_r <= EMPTY;
                  i_full_r <= EMPTY;
                  a_full_r <= EMPTY;
                  s_full_r <= EMPTY;
                  state_r  <= MULTIPLY;
               end else begin
                  f_full_r <= f_full_s;
                  i_full_r <= i_full_s;
                  a_full_r <= a_full_s;
                  s_full_r <= s_full_s;
               end
            end
            MULTIPLY: begin
               fs_product_r <= fs_product_s;
               ia_product_r <= ia_product_s;
               state_r      <= ADDER;
            end
            ADDER: begin
               s_out_r        <= reduce_sum(sum_s);
               s_out_enable_r <= ONE_DATA;
               // Next-element request goes out alongside the result strobe
               request_r      <= last_element_s ? ZERO_DATA : ONE_DATA;
               state_r        <= OUTPUT;
            end
            OUTPUT: begin
               if (last_element_s) begin
                  ready_r <= ONE_DATA;
                  state_r <= STARTER;
               end else begin
                  index_r <= index_r + CONTROL_SIZE'(1'b1);
                  state_r <= INPUT;
               end
            end
            default: begin
               state_r <= STARTER;
            end
         endcase
      end
   end

   assign READY             = ready_r;
   assign F_OUT_ENABLE      = request_r;
   assign I_OUT_ENABLE      = request_r;
   assign A_OUT_ENABLE      = request_r;
   assign S_PREV_OUT_ENABLE = request_r;
   assign S_OUT             = s_out_r;
   assign S_OUT_ENABLE      = s_out_enable_r;

endmodule

// File: tb/tb_accelerator_state_vector.sv
// Directed self-checking bench for accelerator_state_vector (DATA_SIZE=64, 1.0 = 0x1_0000_0000).
module tb_accelerator_state_vector;

   localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
   localparam logic [63:0] HALF    = 64'h0000_0000_8000_0000;
   localparam logic [63:0] QUARTER = 64'h0000_0000_4000_0000;
   localparam logic [63:0] TWO     = 64'h0000_0002_0000_0000;
   localparam logic [63:0] FOUR    = 64'h0000_0004_0000_0000;
   localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;
   localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        START = 1'b0;
   logic        READY;
   logic [63:0] SIZE_L_IN = 64'd0;
   logic [63:0] F_IN = 64'd0, I_IN = 64'd0, A_IN = 64'd0, S_PREV_IN = 64'd0;
   logic        F_IN_ENABLE = 1'b0, I_IN_ENABLE = 1'b0, A_IN_ENABLE = 1'b0, S_PREV_IN_ENABLE = 1'b0;
   logic        F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_PREV_OUT_ENABLE;
   logic [63:0] S_OUT;
   logic        S_OUT_ENABLE;

   int n_assert = 0;
   int n_fail   = 0;
   int n_sout = 0, n_ready = 0, n_req = 0, n_req_with_sout = 0;

   accelerator_state_vector #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_L_IN(SIZE_L_IN),
      .F_IN(F_IN), .I_IN(I_IN), .A_IN(A_IN), .S_PREV_IN(S_PREV_IN),
      .F_IN_ENABLE(F_IN_ENABLE), .I_IN_ENABLE(I_IN_ENABLE),
      .A_IN_ENABLE(A_IN_ENABLE), .S_PREV_IN_ENABLE(S_PREV_IN_ENABLE),
      .F_OUT_ENABLE(F_OUT_ENABLE), .I_OUT_ENABLE(I_OUT_ENABLE),
      .A_OUT_ENABLE(A_OUT_ENABLE), .S_PREV_OUT_ENABLE(S_PREV_OUT_ENABLE),
      .S_OUT(S_OUT), .S_OUT_ENABLE(S_OUT_ENABLE)
   );

   always #5 CLK = ~CLK;

   // Strobe counters sampled on the falling edge
   always @(negedge CLK) begin
      if (RST) begin
         if (S_OUT_ENABLE) n_sout++;
         if (READY) n_ready++;
         if (F_OUT_ENABLE && I_OUT_ENABLE && A_OUT_ENABLE && S_PREV_OUT_ENABLE) n_req++;
         if (F_OUT_ENABLE && S_OUT_ENABLE) n_req_with_sout++;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n_sout = 0; n_ready = 0; n_req = 0; n_req_with_sout = 0;
   endtask

   function automatic logic [63:0] strobes();
      return {58'd0, READY, F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_PREV_OUT_ENABLE, S_OUT_ENABLE};
   endfunction

   task automatic drive_all(input logic [63:0] f, s, i, a);
      F_IN = f; S_PREV_IN = s; I_IN = i; A_IN = a;
      F_IN_ENABLE = 1'b1; S_PREV_IN_ENABLE = 1'b1; I_IN_ENABLE = 1'b1; A_IN_ENABLE = 1'b1;
      tick();
      F_IN_ENABLE = 1'b0; S_PREV_IN_ENABLE = 1'b0; I_IN_ENABLE = 1'b0; A_IN_ENABLE = 1'b0;
   endtask

   // sel: 0=A 1=S 2=I 3=F
   task automatic drive_one(input int sel, input logic [63:0] v);
      case (sel)
         0: begin A_IN = v; A_IN_ENABLE = 1'b1; end
         1: begin S_PREV_IN = v; S_PREV_IN_ENABLE = 1'b1; end
         2: begin I_IN = v; I_IN_ENABLE = 1'b1; end
         default: begin F_IN = v; F_IN_ENABLE = 1'b1; end
      endcase
      tick();
      A_IN_ENABLE = 1'b0; S_PREV_IN_ENABLE = 1'b0; I_IN_ENABLE = 1'b0; F_IN_ENABLE = 1'b0;
   endtask

   task automatic start_vector(input logic [63:0] len);
      SIZE_L_IN = len; START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic run_single(input string tag, input logic [63:0] f, s, i, a, exp);
      start_vector(64'd1);
      check({tag, "_req"}, strobes(), 64'h1E);
      drive_all(f, s, i, a);
      tick(); tick();
      check({tag, "_strobe"}, strobes(), 64'h01);
      check({tag, "_sout"}, S_OUT, exp);
      tick();
      check({tag, "_ready"}, strobes(), 64'h20);
      check({tag, "_hold"}, S_OUT, exp);
      tick();
      check({tag, "_idle"}, strobes(), 64'h00);
   endtask

   logic [63:0] vec_f [3];
   logic [63:0] vec_s [3];
   logic [63:0] vec_i [3];
   logic [63:0] vec_a [3];
   logic [63:0] vec_exp [3];

   initial begin
      vec_f[0] = ONE;  vec_s[0] = ONE;     vec_i[0] = ONE;     vec_a[0] = ONE;  vec_exp[0] = TWO;
      vec_f[1] = HALF; vec_s[1] = HALF;    vec_i[1] = HALF;    vec_a[1] = HALF; vec_exp[1] = HALF;
      vec_f[2] = TWO;  vec_s[2] = NEG_ONE; vec_i[2] = QUARTER; vec_a[2] = FOUR; vec_exp[2] = NEG_ONE;

      // Reset state
      tick(); tick();
      check("reset_strobes", strobes(), 64'h00);
      check("reset_sout", S_OUT, 64'd0);
      RST = 1'b1;
      tick();
      check("idle_strobes", strobes(), 64'h00);

      // L=1 basic: 0.5*2.0 + 1.0*0.25 = 1.25
      run_single("basic", HALF, TWO, ONE, QUARTER, 64'h0000_0001_4000_0000);

      // L=0 completes immediately with no other strobes
      clear_counts();
      start_vector(64'd0);
      check("l0_ready", strobes(), 64'h20);
      tick(); tick();
      check("l0_idle", strobes(), 64'h00);
      check("l0_req_count", 64'(n_req), 64'd0);
      check("l0_sout_count", 64'(n_sout), 64'd0);

      // L=3 staggered operands A,S,I,F with random gaps; mid-vector START ignored
      clear_counts();
      start_vector(64'd3);
      SIZE_L_IN = 64'd7;
      for (int e = 0; e < 3; e++) begin
         repeat ($urandom_range(0, 2)) tick();
         if (e == 1) START = 1'b1;
         drive_one(0, vec_a[e]);
         START = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         drive_one(1, vec_s[e]);
         repeat ($urandom_range(0, 2)) tick();
         drive_one(2, vec_i[e]);
         repeat ($urandom_range(0, 2)) tick();
         drive_one(3, vec_f[e]);
         check($sformatf("vec_e%0d_early", e), 64'(S_OUT_ENABLE), 64'd0);
         tick(); tick();
         check($sformatf("vec_e%0d_strobes", e), strobes(), (e < 2) ? 64'h1F : 64'h01);
         check($sformatf("vec_e%0d_sout", e), S_OUT, vec_exp[e]);
         tick();
      end
      check("vec_ready", 64'(READY), 64'd1);
      tick(); tick();
      check("vec_sout_count", 64'(n_sout), 64'd3);
      check("vec_ready_count", 64'(n_ready), 64'd1);
      check("vec_req_count", 64'(n_req), 64'd3);
      check("vec_req_with_sout", 64'(n_req_with_sout), 64'd2);

      // Overflow: saturates to max or wraps
`ifdef ACCELERATOR_STATE_VECTOR_SATURATION_EN
      run_single("overflow", MAX_POS, MAX_POS, MAX_POS, MAX_POS, MAX_POS);
`else
      run_single("overflow", MAX_POS, MAX_POS, MAX_POS, MAX_POS, 64'hFFFF_FFFE_0000_0000);
`endif

      // Negative: -1.0 * 0.5 = -0.5
      run_single("negative", NEG_ONE, HALF, 64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000);

      // Floor rounding: (1 LSB) * (-1 LSB) = -2^-64 -> floors to -1 LSB
      run_single("floor", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

      // Repeated F enable overwrites the earlier value
      start_vector(64'd1);
      F_IN = 64'h0000_0003_0000_0000; F_IN_ENABLE = 1'b1;
      S_PREV_IN = TWO; S_PREV_IN_ENABLE = 1'b1;
      tick();
      S_PREV_IN_ENABLE = 1'b0;
      F_IN = HALF; I_IN = ONE; A_IN = QUARTER; I_IN_ENABLE = 1'b1; A_IN_ENABLE = 1'b1;
      tick();
      F_IN_ENABLE = 1'b0; I_IN_ENABLE = 1'b0; A_IN_ENABLE = 1'b0;
      tick(); tick();
      check("overwrite_strobe", 64'(S_OUT_ENABLE), 64'd1);
      check("overwrite_sout", S_OUT, 64'h0000_0001_4000_0000);
      tick(); tick();

      // Reset during MULTIPLY of element 1 of L=4
      clear_counts();
      start_vector(64'd4);
      drive_all(ONE, ONE, ONE, ONE);
      tick(); tick();
      check("abort_e0_sout", S_OUT, TWO);
      tick();
      drive_all(HALF, HALF, HALF, HALF);
      RST = 1'b0;
      #1;
      check("abort_strobes", strobes(), 64'h00);
      check("abort_sout", S_OUT, 64'd0);
      tick();
      RST = 1'b1;
      clear_counts();
      repeat (8) tick();
      check("abort_quiet_sout", 64'(n_sout), 64'd0);
      check("abort_quiet_req", 64'(n_req + n_ready), 64'd0);
      run_single("after_abort", HALF, TWO, ONE, QUARTER, 64'h0000_0001_4000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/accelerator_state_vector.md
ACCELERATOR_STATE_VECTOR -- requirements
Module: accelerator_state_vector

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64: operand and result width, signed fixed point with DATA_SIZE/2 fraction bits.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64: element index and counter width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports START (input, 1) and READY (output, 1): start request and one-cycle completion pulse.
REQ-006 SHALL have port SIZE_L_IN, input, DATA_SIZE: vector length L, sampled on accepted START.
REQ-007 SHALL have inputs F_IN, I_IN, A_IN, S_PREV_IN (DATA_SIZE each): forget gate f(t;l), input gate i(t;l), activation a(t;l), previous state s(t-1;l).
REQ-008 SHALL have inputs F_IN_ENABLE, I_IN_ENABLE, A_IN_ENABLE, S_PREV_IN_ENABLE (1 each): the matching data is valid this cycle.
REQ-009 SHALL have outputs F_OUT_ENABLE, I_OUT_ENABLE, A_OUT_ENABLE, S_PREV_OUT_ENABLE (1 each): one-cycle request for the next element from upstream.
REQ-010 SHALL have outputs S_OUT (DATA_SIZE) and S_OUT_ENABLE (1): new state s(t;l) and its one-cycle valid strobe.

Function
REQ-011 SHALL compute s(t;l) = f(t;l)*s(t-1;l) + i(t;l)*a(t;l) for each l in 0..L-1, one element at a time.
REQ-012 SHALL use FSM states STARTER, INPUT, MULTIPLY, ADDER, OUTPUT.
REQ-013 STARTER: on START=1, latch SIZE_L_IN, clear index, pulse all four request enables, go to INPUT; if SIZE_L_IN=0, pulse READY next cycle and stay in STARTER.
REQ-014 INPUT: capture each operand on its enable, in any order and over any number of cycles; go to MULTIPLY in the cycle after the last of the four is captured.
REQ-015 An operand enable repeated before the element completes SHALL overwrite the held value; all four enables in one cycle SHALL be legal.
REQ-016 MULTIPLY: form both full-width products, then shift right by DATA_SIZE/2 with truncation toward minus infinity.
REQ-017 ADDER: form the sum at DATA_SIZE+1 bits, then reduce to DATA_SIZE bits per REQ-027.
REQ-018 OUTPUT: drive S_OUT with S_OUT_ENABLE=1 for exactly one cycle.
REQ-019 Latency: the last operand captured in cycle C SHALL give S_OUT_ENABLE=1 in cycle C+3.
REQ-020 After OUTPUT, if index < L-1: increment index, pulse all four request enables in the same cycle as S_OUT_ENABLE, return to INPUT.
REQ-021 After OUTPUT, if index = L-1: pulse READY in the cycle after S_OUT_ENABLE and go to STARTER.
REQ-022 START outside STARTER SHALL be ignored; SIZE_L_IN changes after acceptance SHALL have no effect.
REQ-023 S_OUT SHALL hold its last value between strobes.

Reset
REQ-024 RST=0 SHALL immediately force state STARTER, index 0, and all held operands to 0.
REQ-025 RST=0 SHALL force READY, every *_OUT_ENABLE and S_OUT_ENABLE to 0, and S_OUT to 0.
REQ-026 Reset during any state SHALL abort the vector with no further strobes; operation resumes only on a new START after release.

Configuration
REQ-027 With ACCELERATOR_STATE_VECTOR_SATURATION_EN defined, product and sum overflow SHALL clamp to the maximum or minimum signed value; without it, results SHALL wrap modulo 2^DATA_SIZE.

Structure
REQ-028 FSM state encoding, ZERO_DATA/ONE_DATA and FULL/EMPTY constants SHALL live in the shared package accelerator_lstm_pkg.
REQ-029 The fixed-point multiply SHALL be the sub-module accelerator_scalar_fixed_multiplier (combinational, optional saturation), instantiated twice.

Verification (DATA_SIZE=64, 1.0 = 0x1_0000_0000)
REQ-030 L=1; f=0.5, s=2.0, i=1.0, a=0.25, all in one cycle C -> S_OUT=0x1_4000_0000 (1.25) at C+3, READY at C+4.
REQ-031 L=3; operands staggered with random gaps, in order A, S, I, F -> three S_OUT strobes, request pulses coinciding with the first two, one READY.
REQ-032 SIZE_L_IN=0 with START -> READY one cycle later; no request or S_OUT strobes.
REQ-033 f=s=i=a=0x7FFF_FFFF_FFFF_FFFF -> S_OUT=0x7FFF_FFFF_FFFF_FFFF with saturation macro; the wrapped value without it.
REQ-034 f=-1.0, s=0.5, i=0, a=0 -> S_OUT=0xFFFF_FFFF_8000_0000 (-0.5).
REQ-035 RST low during MULTIPLY of element 1 of L=4 -> all outputs 0 at once; a new START with L=1 completes normally.
